// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, coordinate width and
// helpers for the derived line/frame totals shared by the VGA timing files.
package vga_timing_pkg;

  localparam int COORD_W   = 11;
  localparam int MAX_TOTAL = (1 << COORD_W) - 1;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_PIX_DIV  = 4;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic line_start;
    logic frame_start;
  } vga_flags_t;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: one-clk pixel strobe every PIX_DIV clks, first strobe PIX_DIV
// clks after reset release. Instantiated only when VGA_PIX_DIV_EN is defined.
module vga_pix_div
  import vga_timing_pkg::*;
#(
  parameter int PIX_DIV = DEF_PIX_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  if (PIX_DIV < 2 || PIX_DIV > 16) begin : g_div_check
    $error("vga_pix_div: PIX_DIV must be in 2..16");
  end

  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count == DIV_LAST) begin
      count <= '0;
    end else begin
      count <= count + 4'd1;
    end
  end

  assign pix_en = (count == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters with registered sync, blanking and start decodes.
// Define VGA_PIX_DIV_EN to derive pix_en from vga_pix_div; otherwise pix_en is tied high.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIX_DIV  = DEF_PIX_DIV
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit coordinate range");
  end

  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam vga_flags_t FLAGS_IDLE = '{
    hsync:       ~SYNC_POL,
    vsync:       ~SYNC_POL,
    video_on:    1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

`ifdef VGA_PIX_DIV_EN
  vga_pix_div #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );
`else
  assign pix_en = 1'b1;
`endif

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  vga_flags_t         flags_d;
  vga_flags_t         flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
      end else begin
        h_cnt <= h_cnt + ONE;
      end
    end
  end

  // Decode the current counter position; registered below so every output
  // describes the same (x, y) one pixel strobe later.
  always_comb begin
    flags_d             = FLAGS_IDLE;
    flags_d.hsync       = (h_cnt >= HS_FIRST && h_cnt <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
    flags_d.vsync       = (v_cnt >= VS_FIRST && v_cnt <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
    flags_d.video_on    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    flags_d.line_start  = (h_cnt == '0);
    flags_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      flags_q <= FLAGS_IDLE;
    end else if (pix_en) begin
      x       <= h_cnt;
      y       <= v_cnt;
      flags_q <= flags_d;
    end
  end

  assign hsync       = flags_q.hsync;
  assign vsync       = flags_q.vsync;
  assign video_on    = flags_q.video_on;
  assign line_start  = flags_q.line_start;
  assign frame_start = flags_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen (divider macro off); one
// default 640x480 instance plus two small-timing instances (active-low and active-high sync).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        pe0, pe1, pe2;
  logic [10:0] x0, y0, x1, y1, x2, y2;
  logic        hs0, vs0, von0, ls0, fs0;
  logic        hs1, vs1, von1, ls1, fs1;
  logic        hs2, vs2, von2, ls2, fs2;

  vga_timing_gen dut0 (
    .clk(clk), .rst(rst), .pix_en(pe0), .x(x0), .y(y0), .hsync(hs0), .vsync(vs0),
    .video_on(von0), .line_start(ls0), .frame_start(fs0)
  );

  // Small timing: H 8+2+3+2 = 15 (hsync x=10..12), V 4+1+2+1 = 8 (vsync y=5..6).
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .PIX_DIV(4)
  ) dut1 (
    .clk(clk), .rst(rst), .pix_en(pe1), .x(x1), .y(y1), .hsync(hs1), .vsync(vs1),
    .video_on(von1), .line_start(ls1), .frame_start(fs1)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1), .PIX_DIV(4)
  ) dut2 (
    .clk(clk), .rst(rst), .pix_en(pe2), .x(x2), .y(y2), .hsync(hs2), .vsync(vs2),
    .video_on(von2), .line_start(ls2), .frame_start(fs2)
  );

  typedef struct {
    int          cyc;
    int          inst;
    string       name;
    logic [27:0] exp;
  } exp_t;

  // Hand-computed vectors: pix_en index after release, x, y, hsync asserted,
  // vsync asserted, video_on, line_start, frame_start.
  typedef struct {
    int idx;
    int x;
    int y;
    bit hs;
    bit vs;
    bit von;
    bit ls;
    bit fs;
  } vec_t;

  vec_t defVec[14] = '{
    '{0,    0,   0, 0, 0, 1, 1, 1},
    '{1,    1,   0, 0, 0, 1, 0, 0},
    '{639,  639, 0, 0, 0, 1, 0, 0},
    '{640,  640, 0, 0, 0, 0, 0, 0},
    '{655,  655, 0, 0, 0, 0, 0, 0},
    '{656,  656, 0, 1, 0, 0, 0, 0},
    '{751,  751, 0, 1, 0, 0, 0, 0},
    '{752,  752, 0, 0, 0, 0, 0, 0},
    '{799,  799, 0, 0, 0, 0, 0, 0},
    '{800,  0,   1, 0, 0, 1, 1, 0},
    '{1456, 656, 1, 1, 0, 0, 0, 0},
    '{1600, 0,   2, 0, 0, 1, 1, 0},
    '{1899, 299, 2, 0, 0, 1, 0, 0},
    '{1900, 300, 2, 0, 0, 1, 0, 0}
  };

  vec_t smallVec[21] = '{
    '{0,   0,  0, 0, 0, 1, 1, 1},
    '{1,   1,  0, 0, 0, 1, 0, 0},
    '{7,   7,  0, 0, 0, 1, 0, 0},
    '{8,   8,  0, 0, 0, 0, 0, 0},
    '{9,   9,  0, 0, 0, 0, 0, 0},
    '{10,  10, 0, 1, 0, 0, 0, 0},
    '{12,  12, 0, 1, 0, 0, 0, 0},
    '{13,  13, 0, 0, 0, 0, 0, 0},
    '{14,  14, 0, 0, 0, 0, 0, 0},
    '{15,  0,  1, 0, 0, 1, 1, 0},
    '{45,  0,  3, 0, 0, 1, 1, 0},
    '{60,  0,  4, 0, 0, 0, 1, 0},
    '{74,  14, 4, 0, 0, 0, 0, 0},
    '{75,  0,  5, 0, 1, 0, 1, 0},
    '{86,  11, 5, 1, 1, 0, 0, 0},
    '{104, 14, 6, 0, 1, 0, 0, 0},
    '{105, 0,  7, 0, 0, 0, 1, 0},
    '{119, 14, 7, 0, 0, 0, 0, 0},
    '{120, 0,  0, 0, 0, 1, 1, 1},
    '{121, 1,  0, 0, 0, 1, 0, 0},
    '{240, 0,  0, 0, 0, 1, 1, 1}
  };

  exp_t sbq[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   winStart = 0;
  int   winEnd   = 0;
  int   hsLowCnt = 0;
  int   hsRun    = 0;
  int   hsMaxRun = 0;
  int   lsCnt    = 0;
  int   fsCnt    = 0;
  int   vonCnt   = 0;

  function automatic logic [27:0] actualOf(int inst);
    case (inst)
      0:       return {pe0, x0, y0, hs0, vs0, von0, ls0, fs0};
      1:       return {pe1, x1, y1, hs1, vs1, von1, ls1, fs1};
      default: return {pe2, x2, y2, hs2, vs2, von2, ls2, fs2};
    endcase
  endfunction

  function automatic string fmt(logic [27:0] v);
    return $sformatf("pe=%b x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
                     v[27], v[26:16], v[15:5], v[4], v[3], v[2], v[1], v[0]);
  endfunction

  // Inserts in cycle order so pushes from different phases can interleave.
  task automatic expectAt(int c, int inst, string name, vec_t v);
    exp_t e;
    logic pol;
    int   i;
    pol    = (inst == 2);
    e.cyc  = c;
    e.inst = inst;
    e.name = name;
    e.exp  = {1'b1, 11'(v.x), 11'(v.y), v.hs ? pol : ~pol, v.vs ? pol : ~pol,
              logic'(v.von), logic'(v.ls), logic'(v.fs)};
    i = sbq.size();
    while (i > 0 && sbq[i-1].cyc > c) i--;
    sbq.insert(i, e);
  endtask

  task automatic expectReset(int c, string tag);
    vec_t r;
    r = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 3; k++) expectAt(c, k, $sformatf("%s_inst%0d", tag, k), r);
  endtask

  task automatic expectRun(int base, string tag, int defLimit, int smallLimit);
    foreach (defVec[i]) begin
      if (defVec[i].idx <= defLimit)
        expectAt(base + defVec[i].idx, 0, $sformatf("%s_def_idx%0d", tag, defVec[i].idx), defVec[i]);
    end
    foreach (smallVec[i]) begin
      if (smallVec[i].idx <= smallLimit) begin
        expectAt(base + smallVec[i].idx, 1, $sformatf("%s_lo_idx%0d", tag, smallVec[i].idx), smallVec[i]);
        expectAt(base + smallVec[i].idx, 2, $sformatf("%s_hi_idx%0d", tag, smallVec[i].idx), smallVec[i]);
      end
    end
  endtask

  task automatic checkOutput();
    logic [27:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      e   = sbq.pop_front();
      act = actualOf(e.inst);
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("[TB] FAIL %s: checked at cycle %0d, required at cycle %0d", e.name, cyc, e.cyc);
      end else if (act !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s: actual %s, required %s", e.name, fmt(act), fmt(e.exp));
      end
    end
  endtask

  task automatic checkCount(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  task automatic waitUntil(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic applyStimulus(logic r, int atCyc);
    waitUntil(atCyc);
    rst = r;
  endtask

  // Monitor: pops due expectations and gathers line statistics for the default instance.
  always @(posedge clk) begin
    cyc++;
    #1;
    checkOutput();
    if (cyc >= winStart && cyc < winEnd) begin
      if (hs0 == 1'b0) begin
        hsLowCnt++;
        hsRun++;
        if (hsRun > hsMaxRun) hsMaxRun = hsRun;
      end else begin
        hsRun = 0;
      end
      if (ls0)  lsCnt++;
      if (fs0)  fsCnt++;
      if (von0) vonCnt++;
    end
  end

  initial begin
    // Reset held for edges 1..3, released so edge 4 shows the first pixel.
    for (int c = 1; c <= 3; c++) expectReset(c, $sformatf("reset_c%0d", c));
    expectRun(4, "run", 1900, 240);
    winStart = 4;
    winEnd   = 1904;
    applyStimulus(1'b0, 3);

    // Mid-frame reset while the default instance shows (300,2) and the small
    // instances are inside both sync pulses; release so edge 1907 restarts.
    expectReset(1905, "midrst_c1905");
    expectReset(1906, "midrst_c1906");
    expectRun(1907, "restart", 800, 121);
    applyStimulus(1'b1, 1904);
    applyStimulus(1'b0, 1906);

    waitUntil(1907 + 810);

    checkCount("hsync_low_pixels", hsLowCnt, 192);
    checkCount("hsync_longest_run", hsMaxRun, 96);
    checkCount("line_start_count", lsCnt, 3);
    checkCount("frame_start_count", fsCnt, 1);
    checkCount("video_on_pixels", vonCnt, 1580);
    checkCount("scoreboard_leftover", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_POL, 0, asserted sync level (0 = active-low)
- PIX_DIV, 4, clk cycles per pixel; used only with VGA_PIX_DIV_EN
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all logic on posedge clk
- rst, in, 1, synchronous active-high reset
- pix_en, out, 1, pixel strobe; outputs update only on cycles with pix_en=1
- x, out, 11, current horizontal position, 0..H_TOTAL-1
- y, out, 11, current vertical position, 0..V_TOTAL-1
- hsync, out, 1, horizontal sync at SYNC_POL level when asserted
- vsync, out, 1, vertical sync at SYNC_POL level when asserted
- video_on, out, 1, high when (x,y) is inside the visible area
- line_start, out, 1, high for one pix_en period when x=0
- frame_start, out, 1, high for one pix_en period when x=0 and y=0

Function
REQ-003 Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-004 The internal counters h_cnt and v_cnt SHALL advance only on pix_en; h_cnt wraps from H_TOTAL-1 to 0. v_cnt increments on that wrap and wraps from V_TOTAL-1 to 0.
REQ-005 All outputs except pix_en SHALL be registered decodes of (h_cnt, v_cnt), loaded on pix_en. This gives a fixed one-pix_en latency, and every output is mutually aligned to the same (x, y).
REQ-006 hsync SHALL equal SYNC_POL for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 656..751); otherwise it SHALL equal ~SYNC_POL.
REQ-007 vsync SHALL equal SYNC_POL for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 490..491), for the full line; otherwise it SHALL equal ~SYNC_POL.
REQ-008 video_on SHALL be 1 if and only if x<H_ACTIVE and y<V_ACTIVE.
REQ-009 Between pix_en strobes, all outputs other than pix_en SHALL hold their values.
REQ-010 Comparisons SHALL use 11-bit unsigned arithmetic; the totals must not exceed 2047 (elaboration check).

Reset
REQ-011 With rst=1 at a clock edge, the following SHALL hold next cycle: h_cnt=0, v_cnt=0, x=0, y=0, hsync=~SYNC_POL, vsync=~SYNC_POL, video_on=0, line_start=0, frame_start=0, and the divider count=0.
REQ-012 Reset SHALL take priority over pix_en. Reset asserted mid-frame SHALL abandon the frame with no partial sync pulse held.
REQ-013 The first pix_en after reset release SHALL present x=0, y=0, video_on=1, line_start=1 and frame_start=1.

Configuration
REQ-014 Macro VGA_PIX_DIV_EN defined: pix_en SHALL pulse high for one clk every PIX_DIV clks. The first pulse is PIX_DIV clks after reset release. PIX_DIV must be 2..16.
REQ-015 Macro VGA_PIX_DIV_EN undefined: pix_en SHALL be constant 1 (including during reset), PIX_DIV SHALL be ignored, and no divider logic shall be present.

Structure
REQ-016 Package vga_timing_pkg SHALL hold the default 640x480@60 timing constants, the coordinate width constant (11), and the derived H_TOTAL/V_TOTAL functions.
REQ-017 The pixel-strobe divider SHALL be the sub-module vga_pix_div, instantiated only under VGA_PIX_DIV_EN. The counters and decode SHALL stay in vga_timing_gen.

Verification
REQ-018 Startup test, macro off, defaults.
- Stimulus: rst high for 3 clks, then release.
- Response: first cycle shows x=0, y=0, video_on=1, frame_start=1. The next cycle shows x=1 and frame_start=0.
REQ-019 Line timing test.
- Check across one line: hsync=0 for exactly 96 consecutive pix_en at x=656..751.
- Check video_on=0 for x=640..799.
- Check line_start recurs every 800 pix_en.
REQ-020 Frame timing test.
- Check vsync=0 at y=490..491 only.
- Check frame_start recurs every 420000 pix_en.
- Check the wrap from (799,524) to (0,0) with y incrementing at each x wrap.
REQ-021 Mid-frame reset test.
- Stimulus: assert rst at x=300, y=200.
- Response: next cycle shows the REQ-011 values. After release, the output restarts at (0,0) with frame_start=1.
REQ-022 Divider test, macro on, PIX_DIV=4.
- Check pix_en is high 1 clk in 4.
- Check x, y and the syncs change only on the clk after pix_en and hold for 4 clks.
- Check frame_start is high for exactly 1 pix_en period, i.e. 4 clks.
REQ-023 Polarity test, SYNC_POL=1.
- Check that hsync and vsync are inverted relative to REQ-019 and REQ-020, with identical position windows.
